instr_sequencer: RTL and testbench

//   Producer side of the 16-bit instruction stream that the controller unit decodes.

---
 rtl/ctrl_pkg.sv | 18 +
 rtl/instr_mem.sv | 34 +++
 rtl/instr_sequencer.sv | 140 ++++++++++++++
 tb/tb_instr_sequencer.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared definitions for the instruction sequencer and the controller it feeds.
//   INSTR_W          : instruction width seen by the controller
//   OPC_MSB/OPC_LSB  : bit range of the ALU control field inside an instruction
//   seq_state_t      : sequencer FSM states
package ctrl_pkg;

  localparam int unsigned INSTR_W = 16;
  localparam int unsigned OPC_MSB = 15;
  localparam int unsigned OPC_LSB = 13;

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StIssue,
    StDone
  } seq_state_t;

endpackage

// File: rtl/instr_mem.sv
// Program store: 2**ADDR_W x INSTR_W flop array, synchronous write, asynchronous read.
// Contents are deliberately not reset so a program survives a sequencer reset.
// Ports:
//   clk    : write clock
//   we     : write enable
//   waddr  : write address
//   wdata  : write data
//   raddr  : read address
//   rdata  : read data (combinational from raddr)
module instr_mem #(
  parameter int unsigned ADDR_W  = 5,
  parameter int unsigned INSTR_W = 16
) (
  input  logic               clk,
  input  logic               we,
  input  logic [ADDR_W-1:0]  waddr,
  input  logic [INSTR_W-1:0] wdata,
  input  logic [ADDR_W-1:0]  raddr,
  output logic [INSTR_W-1:0] rdata
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  logic [INSTR_W-1:0] mem [Depth];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/instr_sequencer.sv
// Instruction sequencer: steps a pc through a loadable program store and issues one
// instruction per valid/ready handshake, with optional wrap-around looping.
// Ports:
//   clk, rst_n         : clock, asynchronous active-low reset
//   load_en/addr/data  : program-store write, ignored while busy
//   start, stop        : begin at pc=0 (from IDLE/DONE) / abort to IDLE
//   end_addr           : last pc, captured when start is accepted
//   loop_en            : wrap to pc=0 after end_q instead of finishing (sampled live)
//   instr_ready        : consumer accepts instr this cycle
//   instr_valid, instr : issued instruction (instr is zero when not valid)
//   pc                 : address of the instruction on instr
//   busy, done         : FETCH/ISSUE in progress; program completed
module instr_sequencer
  import ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W  = 5,
  parameter int unsigned INSTR_W = ctrl_pkg::INSTR_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_en,
  input  logic [ADDR_W-1:0]  load_addr,
  input  logic [INSTR_W-1:0] load_data,
  input  logic               start,
  input  logic               stop,
  input  logic [ADDR_W-1:0]  end_addr,
  input  logic               loop_en,
  input  logic               instr_ready,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  pc,
  output logic               busy,
  output logic               done
);

  seq_state_t         state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [ADDR_W-1:0]  end_q, end_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic               valid_q, valid_d;

  logic               at_end;
  logic [ADDR_W-1:0]  pc_wrap;
  logic [ADDR_W-1:0]  rd_addr;
  logic [INSTR_W-1:0] rd_data;
  logic               mem_we;

  assign busy   = (state_q == StFetch) || (state_q == StIssue);
  assign mem_we = load_en && !busy;

  // Address of the instruction that follows pc_q; when the run finishes the read is unused.
  assign at_end  = (pc_q == end_q);
  assign pc_wrap = at_end ? '0 : pc_q + 1'b1;
  // FETCH reads the current pc; ISSUE prefetches the successor so a handshake every cycle
  // streams without bubbles.
  assign rd_addr = (state_q == StIssue) ? pc_wrap : pc_q;

  instr_mem #(
    .ADDR_W (ADDR_W),
    .INSTR_W(INSTR_W)
  ) u_instr_mem (
    .clk  (clk),
    .we   (mem_we),
    .waddr(load_addr),
    .wdata(load_data),
    .raddr(rd_addr),
    .rdata(rd_data)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    end_d   = end_q;
    instr_d = instr_q;
    valid_d = valid_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (stop) begin
          state_d = StIdle;
        end else if (start) begin
          state_d = StFetch;
          pc_d    = '0;
          end_d   = end_addr;
        end
      end
      StFetch: begin
        if (stop) begin
          state_d = StIdle;
        end else begin
          state_d = StIssue;
          instr_d = rd_data;
          valid_d = 1'b1;
        end
      end
      StIssue: begin
        if (stop) begin
          state_d = StIdle;
          instr_d = '0;
          valid_d = 1'b0;
        end else if (instr_ready) begin
          if (!at_end || loop_en) begin
            pc_d    = pc_wrap;
            instr_d = rd_data;
          end else begin
            state_d = StDone;
            instr_d = '0;
            valid_d = 1'b0;
          end
        end
      end
      default: begin
        state_d = StIdle;
        instr_d = '0;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      pc_q    <= '0;
      end_q   <= '0;
      instr_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      end_q   <= end_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
    end
  end

  assign instr_valid = valid_q;
  assign instr       = instr_q;
  assign pc          = pc_q;
  assign done        = (state_q == StDone);

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer. A model of the program store produces the
// expected instruction stream; expected {pc, instr} pairs are queued when a run is
// started and popped as handshakes happen.
module tb_instr_sequencer;

  typedef struct packed {
    logic [4:0]  pc;
    logic [15:0] instr;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        load_en;
  logic [4:0]  load_addr;
  logic [15:0] load_data;
  logic        start;
  logic        stop;
  logic [4:0]  end_addr;
  logic        loop_en;
  logic        instr_ready;
  logic        instr_valid;
  logic [15:0] instr;
  logic [4:0]  pc;
  logic        busy;
  logic        done;

  logic [15:0] model_mem [32];
  exp_t        sb [$];
  int          vectors;
  int          miscompares;

  instr_sequencer #(
    .ADDR_W (5),
    .INSTR_W(16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_en    (load_en),
    .load_addr  (load_addr),
    .load_data  (load_data),
    .start      (start),
    .stop       (stop),
    .end_addr   (end_addr),
    .loop_en    (loop_en),
    .instr_ready(instr_ready),
    .instr_valid(instr_valid),
    .instr      (instr),
    .pc         (pc),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; sample point is 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // taken=1 when the sequencer is expected to accept the write (not busy).
  task automatic load_word(input logic [4:0] a, input logic [15:0] d, input bit taken);
    load_en   = 1'b1;
    load_addr = a;
    load_data = d;
    tick();
    load_en = 1'b0;
    if (taken) model_mem[a] = d;
  endtask

  // Pulse start and queue the n instructions the run should issue.
  task automatic start_run(input logic [4:0] ea, input logic lp, input int n);
    logic [4:0] p;
    end_addr = ea;
    loop_en  = lp;
    start    = 1'b1;
    p        = '0;
    for (int i = 0; i < n; i++) begin
      sb.push_back('{pc: p, instr: model_mem[p]});
      p = (p == ea) ? 5'd0 : p + 5'd1;
    end
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    vectors++;
    if (instr_valid !== 1'b0 || instr !== 16'h0 || pc !== 5'd0 || busy !== 1'b0
        || done !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_outputs: got valid=%b instr=%h pc=%0d busy=%b done=%b want all 0",
               instr_valid, instr, pc, busy, done);
    end
  endtask

  task automatic test_basic();
    exp_t e;
    load_word(5'd0, 16'hA100, 1'b1);
    load_word(5'd1, 16'hD1FE, 1'b1);
    load_word(5'd2, 16'hF900, 1'b1);
    instr_ready = 1'b1;
    start_run(5'd2, 1'b0, 3);
    vectors++;
    if (instr_valid !== 1'b0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL basic_fetch: got valid=%b busy=%b want valid=0 busy=1", instr_valid, busy);
    end
    tick();
    for (int i = 0; i < 3; i++) begin
      e = sb.pop_front();
      vectors++;
      if (instr_valid !== 1'b1 || instr !== e.instr || pc !== e.pc) begin
        miscompares++;
        $display("FAIL basic_issue%0d: got valid=%b instr=%h pc=%0d want valid=1 instr=%h pc=%0d",
                 i, instr_valid, instr, pc, e.instr, e.pc);
      end
      tick();
    end
    vectors++;
    if (done !== 1'b1 || instr_valid !== 1'b0 || instr !== 16'h0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_done: got done=%b valid=%b instr=%h busy=%b want 1 0 0000 0",
               done, instr_valid, instr, busy);
    end
  endtask

  task automatic test_stall();
    exp_t e;
    instr_ready = 1'b1;
    start_run(5'd2, 1'b0, 3);
    tick();
    e = sb.pop_front();
    vectors++;
    if (instr !== e.instr || pc !== e.pc) begin
      miscompares++;
      $display("FAIL stall_first: got instr=%h pc=%0d want %h %0d", instr, pc, e.instr, e.pc);
    end
    tick();
    instr_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (instr_valid !== 1'b1 || instr !== sb[0].instr || pc !== sb[0].pc) begin
        miscompares++;
        $display("FAIL stall_hold%0d: got valid=%b instr=%h pc=%0d want 1 %h %0d",
                 i, instr_valid, instr, pc, sb[0].instr, sb[0].pc);
      end
      tick();
    end
    instr_ready = 1'b1;
    for (int c = 0; c < 10 && sb.size() != 0; c++) begin
      if (instr_valid && instr_ready) begin
        e = sb.pop_front();
        vectors++;
        if (instr !== e.instr || pc !== e.pc) begin
          miscompares++;
          $display("FAIL stall_drain: got instr=%h pc=%0d want %h %0d", instr, pc, e.instr, e.pc);
        end
      end
      tick();
    end
    vectors++;
    if (sb.size() != 0 || done !== 1'b1) begin
      miscompares++;
      $display("FAIL stall_end: got pending=%0d done=%b want 0 1", sb.size(), done);
      sb.delete();
    end
  endtask

  task automatic test_loop();
    exp_t e;
    instr_ready = 1'b1;
    start_run(5'd1, 1'b1, 5);
    tick();
    for (int c = 0; c < 10 && sb.size() != 0; c++) begin
      if (instr_valid && instr_ready) begin
        e = sb.pop_front();
        vectors++;
        if (instr !== e.instr || pc !== e.pc || done !== 1'b0 || busy !== 1'b1) begin
          miscompares++;
          $display("FAIL loop_issue: got instr=%h pc=%0d done=%b busy=%b want %h %0d 0 1",
                   instr, pc, done, busy, e.instr, e.pc);
        end
      end
      tick();
    end
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL loop_timeout: got pending=%0d want 0", sb.size());
      sb.delete();
    end
  endtask

  // Follows test_loop: the looping run is still active with pc=1 on the output.
  task automatic test_stop();
    exp_t e;
    vectors++;
    if (pc !== 5'd1 || instr !== 16'hD1FE || instr_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL stop_pre: got pc=%0d instr=%h valid=%b want 1 D1FE 1", pc, instr, instr_valid);
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    vectors++;
    if (instr_valid !== 1'b0 || instr !== 16'h0 || busy !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL stop_idle: got valid=%b instr=%h busy=%b done=%b want 0 0000 0 0",
               instr_valid, instr, busy, done);
    end
    start_run(5'd2, 1'b0, 3);
    tick();
    for (int c = 0; c < 10 && sb.size() != 0; c++) begin
      if (instr_valid && instr_ready) begin
        e = sb.pop_front();
        vectors++;
        if (instr !== e.instr || pc !== e.pc) begin
          miscompares++;
          $display("FAIL stop_restart: got instr=%h pc=%0d want %h %0d", instr, pc, e.instr, e.pc);
        end
      end
      tick();
    end
    vectors++;
    if (sb.size() != 0 || done !== 1'b1) begin
      miscompares++;
      $display("FAIL stop_end: got pending=%0d done=%b want 0 1", sb.size(), done);
      sb.delete();
    end
  endtask

  task automatic test_load_busy();
    exp_t e;
    for (int pass = 0; pass < 2; pass++) begin
      instr_ready = 1'b0;
      start_run(5'd2, 1'b0, 3);
      tick();
      if (pass == 0) load_word(5'd0, 16'h1C80, 1'b0);
      instr_ready = 1'b1;
      for (int c = 0; c < 10 && sb.size() != 0; c++) begin
        if (instr_valid && instr_ready) begin
          e = sb.pop_front();
          vectors++;
          if (instr !== e.instr || pc !== e.pc) begin
            miscompares++;
            $display("FAIL load_run%0d: got instr=%h pc=%0d want %h %0d",
                     pass, instr, pc, e.instr, e.pc);
          end
        end
        tick();
      end
      vectors++;
      if (sb.size() != 0 || done !== 1'b1) begin
        miscompares++;
        $display("FAIL load_end%0d: got pending=%0d done=%b want 0 1", pass, sb.size(), done);
        sb.delete();
      end
      if (pass == 0) begin
        stop = 1'b1;
        tick();
        stop = 1'b0;
        vectors++;
        if (done !== 1'b0 || busy !== 1'b0) begin
          miscompares++;
          $display("FAIL load_idle: got done=%b busy=%b want 0 0", done, busy);
        end
        load_word(5'd0, 16'h1C80, 1'b1);
      end
    end
    load_word(5'd0, 16'hA100, 1'b1);
  endtask

  task automatic test_async_reset();
    exp_t e;
    instr_ready = 1'b1;
    start_run(5'd2, 1'b0, 3);
    tick();
    e = sb.pop_front();
    vectors++;
    if (instr !== e.instr || pc !== e.pc) begin
      miscompares++;
      $display("FAIL arst_first: got instr=%h pc=%0d want %h %0d", instr, pc, e.instr, e.pc);
    end
    tick();
    #2 rst_n = 1'b0;
    #1;
    sb.delete();
    vectors++;
    if (instr_valid !== 1'b0 || instr !== 16'h0 || pc !== 5'd0 || busy !== 1'b0
        || done !== 1'b0) begin
      miscompares++;
      $display("FAIL arst_outputs: got valid=%b instr=%h pc=%0d busy=%b done=%b want all 0",
               instr_valid, instr, pc, busy, done);
    end
    #2 rst_n = 1'b1;
    start_run(5'd2, 1'b0, 3);
    tick();
    for (int c = 0; c < 10 && sb.size() != 0; c++) begin
      if (instr_valid && instr_ready) begin
        e = sb.pop_front();
        vectors++;
        if (instr !== e.instr || pc !== e.pc) begin
          miscompares++;
          $display("FAIL arst_rerun: got instr=%h pc=%0d want %h %0d", instr, pc, e.instr, e.pc);
        end
      end
      tick();
    end
    vectors++;
    if (sb.size() != 0 || done !== 1'b1) begin
      miscompares++;
      $display("FAIL arst_end: got pending=%0d done=%b want 0 1", sb.size(), done);
      sb.delete();
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    load_en     = 1'b0;
    load_addr   = '0;
    load_data   = '0;
    start       = 1'b0;
    stop        = 1'b0;
    end_addr    = '0;
    loop_en     = 1'b0;
    instr_ready = 1'b0;
    for (int i = 0; i < 32; i++) model_mem[i] = 16'h0;
    tick();
    tick();
    test_reset();
    rst_n = 1'b1;
    tick();
    test_reset();
    test_basic();
    test_stall();
    test_loop();
    test_stop();
    test_load_busy();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
